// File: rtl/btn_cond_pkg.sv
// Shared types and default parameter values for the btn_cond push-button conditioner.
package btn_cond_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    DOWN       = 2'd2,
    REL_WAIT   = 2'd3
  } deb_state_e;

  localparam int DEB_CYC_DEF  = 16;
  localparam int HOLD_CYC_DEF = 64;

endpackage

// File: rtl/btn_cond_if.sv
// Raw button levels in, conditioned start/stop pulses and mode level out.
interface btn_cond_if;

  logic btn_start_raw;
  logic btn_stop_raw;
  logic btn_mode_raw;
  logic start;
  logic stop;
  logic mode;

  modport master (
    output btn_start_raw, btn_stop_raw, btn_mode_raw,
    input  start, stop, mode
  );

  modport slave (
    input  btn_start_raw, btn_stop_raw, btn_mode_raw,
    output start, stop, mode
  );

endinterface

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, debounce counter and FSM with a registered press pulse.
//   state      | meaning
//   IDLE       | released and stable
//   PRESS_WAIT | sync high, counting towards an accepted press
//   DOWN       | press accepted, button held
//   REL_WAIT   | sync low, counting towards an accepted release
module btn_debounce
  import btn_cond_pkg::*;
#(
  parameter int DEB_CYC = DEB_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press,
  output logic level
);

  localparam int CNT_W = $clog2(DEB_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

  logic             meta;
  logic             sync;
  deb_state_e       state_q;
  deb_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             press_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      press   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press   <= press_d;
    end
  end

  // The counter stops at CNT_LAST because reaching it always leaves the wait state.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    press_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync) state_d = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!sync) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DOWN;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DOWN: begin
        if (!sync) state_d = REL_WAIT;
      end
      REL_WAIT: begin
        if (sync) begin
          state_d = DOWN;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign level = (state_q == DOWN) || (state_q == REL_WAIT);

endmodule

// File: rtl/btn_cond.sv
// Button conditioner top: three debouncers, stop-over-start arbitration and the mode toggle.
// Optional BTN_COND_HOLD_EN: holding stop for HOLD_CYC cycles forces mode back to 0.
module btn_cond
  import btn_cond_pkg::*;
#(
  parameter int DEB_CYC  = DEB_CYC_DEF,
  parameter int HOLD_CYC = HOLD_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  btn_cond_if.slave  bus
);

  logic press_start;
  logic press_stop;
  logic press_mode;
  logic lvl_start;
  logic lvl_stop;
  logic lvl_mode;
  logic mode_q;
  logic force_zero;

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_start (
    .clk   (clk),
    .rst   (rst),
    .raw   (bus.btn_start_raw),
    .press (press_start),
    .level (lvl_start)
  );

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_stop (
    .clk   (clk),
    .rst   (rst),
    .raw   (bus.btn_stop_raw),
    .press (press_stop),
    .level (lvl_stop)
  );

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_mode (
    .clk   (clk),
    .rst   (rst),
    .raw   (bus.btn_mode_raw),
    .press (press_mode),
    .level (lvl_mode)
  );

  assign bus.start = press_start & ~press_stop;
  assign bus.stop  = press_stop;

  // mode_q holds the settled value; the output already reflects a toggle in the press cycle.
  assign bus.mode = force_zero ? 1'b0 : (mode_q ^ press_mode);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mode_q <= 1'b0;
    else     mode_q <= bus.mode;
  end

`ifdef BTN_COND_HOLD_EN
  localparam int HOLD_W = $clog2(HOLD_CYC + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);

  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_done;
  logic              unused_lvl;

  assign unused_lvl = lvl_start ^ lvl_mode;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt   <= '0;
      hold_done  <= 1'b0;
      force_zero <= 1'b0;
    end else begin
      force_zero <= 1'b0;
      if (!lvl_stop) begin
        hold_cnt  <= '0;
        hold_done <= 1'b0;
      end else if (!hold_done) begin
        if (hold_cnt == HOLD_LAST) begin
          force_zero <= 1'b1;
          hold_done  <= 1'b1;
          hold_cnt   <= '0;
        end else begin
          hold_cnt <= hold_cnt + HOLD_W'(1);
        end
      end
    end
  end
`else
  localparam int unused_hold_cyc = HOLD_CYC;
  logic unused_lvl;

  assign unused_lvl = lvl_start ^ lvl_stop ^ lvl_mode;
  assign force_zero = 1'b0;
`endif

endmodule

// File: tb/tb_btn_cond.sv
// Directed bench for btn_cond with DEB_CYC=4, HOLD_CYC=12.
module tb_btn_cond;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic exp_mode;

  btn_cond_if bus ();

  btn_cond #(.DEB_CYC(4), .HOLD_CYC(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic es;
    rst = 1'b1;
    bus.btn_start_raw = 1'b0;
    bus.btn_stop_raw  = 1'b0;
    bus.btn_mode_raw  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.start, bus.stop, bus.mode} !== 3'b000) begin
      errors++;
      $display("FAIL reset_init: got %b expected 000", {bus.start, bus.stop, bus.mode});
    end
    rst = 1'b0;
    bus.btn_start_raw = 1'b1;
    bus.btn_stop_raw  = 1'b1;
    bus.btn_mode_raw  = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      cycle();
      es = (i == 7);
      checks++;
      if ({bus.start, bus.stop, bus.mode} !== {1'b0, es, es}) begin
        errors++;
        $display("FAIL reset_first_press cycle %0d: got %b expected %b", i,
                 {bus.start, bus.stop, bus.mode}, {1'b0, es, es});
      end
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({bus.start, bus.stop, bus.mode} !== 3'b000) begin
      errors++;
      $display("FAIL reset_async: got %b expected 000", {bus.start, bus.stop, bus.mode});
    end
    #1 rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cycle();
      checks++;
      if ({bus.start, bus.stop, bus.mode} !== {1'b0, (i == 7), (i >= 7)}) begin
        errors++;
        $display("FAIL reset_held_press cycle %0d: got %b expected %b", i,
                 {bus.start, bus.stop, bus.mode}, {1'b0, (i == 7), (i >= 7)});
      end
    end
    bus.btn_start_raw = 1'b0;
    bus.btn_stop_raw  = 1'b0;
    bus.btn_mode_raw  = 1'b0;
    exp_mode = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      checks++;
      if ({bus.start, bus.stop, bus.mode} !== {2'b00, exp_mode}) begin
        errors++;
        $display("FAIL reset_release cycle %0d: got %b expected %b", i,
                 {bus.start, bus.stop, bus.mode}, {2'b00, exp_mode});
      end
    end
  endtask

  task automatic test_clean_press();
    bus.btn_start_raw = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      checks++;
      if ({bus.start, bus.stop, bus.mode} !== {(i == 7), 1'b0, exp_mode}) begin
        errors++;
        $display("FAIL clean_press cycle %0d: got %b expected %b", i,
                 {bus.start, bus.stop, bus.mode}, {(i == 7), 1'b0, exp_mode});
      end
    end
    bus.btn_start_raw = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      cycle();
      checks++;
      if (bus.start !== 1'b0) begin
        errors++;
        $display("FAIL clean_release cycle %0d: got %b expected 0", i, bus.start);
      end
    end
  endtask

  task automatic test_bounce();
    logic [6:0] pat;
    pat = 7'b1101110;
    for (int i = 6; i >= 0; i--) begin
      bus.btn_stop_raw = pat[i];
      cycle();
      checks++;
      if (bus.stop !== 1'b0) begin
        errors++;
        $display("FAIL bounce_reject step %0d: got %b expected 0", 6 - i, bus.stop);
      end
    end
    for (int i = 1; i <= 5; i++) begin
      cycle();
      checks++;
      if (bus.stop !== 1'b0) begin
        errors++;
        $display("FAIL bounce_tail cycle %0d: got %b expected 0", i, bus.stop);
      end
    end
    bus.btn_stop_raw = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      checks++;
      if ({bus.start, bus.stop} !== {1'b0, (i == 7)}) begin
        errors++;
        $display("FAIL bounce_hold cycle %0d: got %b expected %b", i,
                 {bus.start, bus.stop}, {1'b0, (i == 7)});
      end
    end
    bus.btn_stop_raw = 1'b0;
    repeat (10) cycle();
  endtask

  task automatic test_simultaneous();
    bus.btn_start_raw = 1'b1;
    bus.btn_stop_raw  = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      checks++;
      if ({bus.start, bus.stop, bus.mode} !== {1'b0, (i == 7), exp_mode}) begin
        errors++;
        $display("FAIL simultaneous cycle %0d: got %b expected %b", i,
                 {bus.start, bus.stop, bus.mode}, {1'b0, (i == 7), exp_mode});
      end
    end
    bus.btn_start_raw = 1'b0;
    bus.btn_stop_raw  = 1'b0;
    repeat (10) cycle();
  endtask

  task automatic mode_press(input int hold);
    bus.btn_mode_raw = 1'b1;
    for (int i = 1; i <= hold; i++) begin
      cycle();
      if (i == 7) exp_mode = ~exp_mode;
      checks++;
      if ({bus.start, bus.stop, bus.mode} !== {2'b00, exp_mode}) begin
        errors++;
        $display("FAIL mode_press hold %0d cycle %0d: got %b expected %b", hold, i,
                 {bus.start, bus.stop, bus.mode}, {2'b00, exp_mode});
      end
    end
    bus.btn_mode_raw = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      checks++;
      if (bus.mode !== exp_mode) begin
        errors++;
        $display("FAIL mode_release cycle %0d: got %b expected %b", i, bus.mode, exp_mode);
      end
    end
  endtask

  task automatic test_mode_toggle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    exp_mode = 1'b0;
    checks++;
    if (bus.mode !== 1'b0) begin
      errors++;
      $display("FAIL mode_after_reset: got %b expected 0", bus.mode);
    end
    mode_press(8);
    mode_press(8);
    mode_press(8);
    mode_press(30);
  endtask

  task automatic test_stop_hold();
    mode_press(8);
    bus.btn_stop_raw = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      cycle();
`ifdef BTN_COND_HOLD_EN
      if (i == 19) exp_mode = 1'b0;
`endif
      checks++;
      if ({bus.stop, bus.mode} !== {(i == 7), exp_mode}) begin
        errors++;
        $display("FAIL stop_hold cycle %0d: got %b expected %b", i,
                 {bus.stop, bus.mode}, {(i == 7), exp_mode});
      end
    end
    bus.btn_stop_raw = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      checks++;
      if ({bus.stop, bus.mode} !== {1'b0, exp_mode}) begin
        errors++;
        $display("FAIL stop_hold_release cycle %0d: got %b expected %b", i,
                 {bus.stop, bus.mode}, {1'b0, exp_mode});
      end
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    exp_mode = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_mode_toggle();
    test_stop_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
